input_state_fifo: RTL and testbench

Parametrised buffer for Skein input states, placed between the host/candidate source and the hash core. It holds up to DEPTH states of WIDTH bits and presents them to the hash core in first-in, first-out order on a valid/ready handshake. It keeps the synchronous zero command of the single-entry register, and adds occupancy status and a sticky overflow flag.

---
 rtl/input_state_fifo_if.sv | 37 +++
 rtl/input_state_fifo.sv | 100 ++++++++++
 tb/tb_input_state_fifo.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/input_state_fifo_if.sv
// Handshake bundle between the state source, the input state FIFO and the hash core.
// incr_i exists only when INPUT_FIFO_AUTOINC_EN is defined.
interface input_state_fifo_if #(
    parameter int WIDTH = 1024,
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             zero_i;
    logic             write_i;
    logic [WIDTH-1:0] state_i;
    logic             wr_ready_o;
    logic             read_i;
    logic             valid_o;
    logic [WIDTH-1:0] state_o;
    logic [CNT_W-1:0] count_o;
    logic             overflow_o;
`ifdef INPUT_FIFO_AUTOINC_EN
    logic             incr_i;
`endif

    modport master (
        output zero_i, write_i, state_i, read_i,
`ifdef INPUT_FIFO_AUTOINC_EN
        output incr_i,
`endif
        input  wr_ready_o, valid_o, state_o, count_o, overflow_o
    );

    modport slave (
        input  zero_i, write_i, state_i, read_i,
`ifdef INPUT_FIFO_AUTOINC_EN
        input  incr_i,
`endif
        output wr_ready_o, valid_o, state_o, count_o, overflow_o
    );
endinterface

// File: rtl/input_state_fifo.sv
// First-word fall-through FIFO of Skein input states with synchronous zero, occupancy and sticky overflow.
// Optional INPUT_FIFO_AUTOINC_EN: a pop with incr_i set increments the head in place instead of removing it.
module input_state_fifo #(
    parameter int WIDTH = 1024,
    parameter int DEPTH = 4
) (
    input logic                clk_i,
    input logic                rst_n_i,
    input_state_fifo_if.slave  bus
);
    localparam int ADDR  = $clog2(DEPTH);
    localparam int CNT_W = ADDR + 1;

    logic [ADDR-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [ADDR-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg,  count_next;
    logic             overflow_reg, overflow_next;
    logic [WIDTH-1:0] entry_q [DEPTH];

    logic full, empty, push, pop_acc, pop, inc;

    // Status comes only from registered state, so ready never combinationally depends on read_i.
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push    = bus.write_i && !full;
    assign pop_acc = bus.read_i && !empty;

`ifdef INPUT_FIFO_AUTOINC_EN
    assign inc = pop_acc && bus.incr_i;
    assign pop = pop_acc && !bus.incr_i;
`else
    assign inc = 1'b0;
    assign pop = pop_acc;
`endif

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;
        if (bus.zero_i) begin
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            count_next    = '0;
            overflow_next = 1'b0;
        end else begin
            if (push)
                wr_ptr_next = wr_ptr_reg + ADDR'(1);
            if (pop)
                rd_ptr_next = rd_ptr_reg + ADDR'(1);
            if (push && !pop)
                count_next = count_reg + CNT_W'(1);
            else if (pop && !push)
                count_next = count_reg - CNT_W'(1);
            if (bus.write_i && full)
                overflow_next = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end

    // Each entry is its own register so reset and zero can clear the whole store at once.
    // A push and an increment never hit the same slot: increment needs non-empty, push needs non-full.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_reg;

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i)
                    entry_reg <= '0;
                else if (bus.zero_i)
                    entry_reg <= '0;
                else if (push && (wr_ptr_reg == ADDR'(gi)))
                    entry_reg <= bus.state_i;
                else if (inc && (rd_ptr_reg == ADDR'(gi)))
                    entry_reg <= entry_reg + WIDTH'(1);
            end

            assign entry_q[gi] = entry_reg;
        end
    endgenerate

    assign bus.wr_ready_o = !full;
    assign bus.valid_o    = !empty;
    assign bus.state_o    = empty ? '0 : entry_q[rd_ptr_reg];
    assign bus.count_o    = count_reg;
    assign bus.overflow_o = overflow_reg;
endmodule

// File: tb/tb_input_state_fifo.sv
// Directed bench for input_state_fifo (WIDTH=16, DEPTH=4) using immediate assertions.
// The increment scenario runs only when INPUT_FIFO_AUTOINC_EN is defined.
module tb_input_state_fifo;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    input_state_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    input_state_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; outputs are sampled 1 time unit after the rising edge.
    task automatic cyc(input logic w, input logic [WIDTH-1:0] d, input logic r, input logic z);
        bus.write_i = w;
        bus.state_i = d;
        bus.read_i  = r;
        bus.zero_i  = z;
        @(posedge clk);
        #1;
        bus.write_i = 1'b0;
        bus.state_i = '0;
        bus.read_i  = 1'b0;
        bus.zero_i  = 1'b0;
        $display("txn w=%0b d=%0h r=%0b z=%0b -> count=%0d valid=%0b head=%0h ovf=%0b",
                 w, d, r, z, bus.count_o, bus.valid_o, bus.state_o, bus.overflow_o);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [WIDTH-1:0] exp_head [6];
        exp_head[0] = 16'h21; exp_head[1] = 16'h10; exp_head[2] = 16'h11;
        exp_head[3] = 16'h12; exp_head[4] = 16'h13; exp_head[5] = 16'h14;

        checks = 0;
        errors = 0;
        rst_n       = 1'b0;
        bus.write_i = 1'b0;
        bus.state_i = '0;
        bus.read_i  = 1'b0;
        bus.zero_i  = 1'b0;
`ifdef INPUT_FIFO_AUTOINC_EN
        bus.incr_i  = 1'b0;
`endif
        #12;
        chk("rst_count", 32'(bus.count_o), 0);
        chk("rst_valid", 32'(bus.valid_o), 0);
        chk("rst_ready", 32'(bus.wr_ready_o), 1);
        chk("rst_ovf",   32'(bus.overflow_o), 0);
        chk("rst_state", 32'(bus.state_o), 0);
        rst_n = 1'b1;

        // Fill with A, B, C then drain in order.
        cyc(1, 16'hA, 0, 0);
        chk("fwft_valid", 32'(bus.valid_o), 1);
        chk("fwft_state", 32'(bus.state_o), 32'hA);
        cyc(1, 16'hB, 0, 0);
        cyc(1, 16'hC, 0, 0);
        chk("abc_count", 32'(bus.count_o), 3);
        chk("abc_head",  32'(bus.state_o), 32'hA);
        cyc(0, 0, 1, 0);
        chk("pop1_head", 32'(bus.state_o), 32'hB);
        cyc(0, 0, 1, 0);
        chk("pop2_head", 32'(bus.state_o), 32'hC);
        cyc(0, 0, 1, 0);
        chk("pop3_valid", 32'(bus.valid_o), 0);
        chk("pop3_state", 32'(bus.state_o), 0);
        chk("pop3_count", 32'(bus.count_o), 0);
        cyc(0, 0, 1, 0);
        chk("pop_empty_count", 32'(bus.count_o), 0);

        // Overfill with 1..5; the 5th push is rejected.
        for (int i = 1; i <= 4; i++) cyc(1, 16'(i), 0, 0);
        chk("full_ready", 32'(bus.wr_ready_o), 0);
        chk("full_count", 32'(bus.count_o), 4);
        chk("full_ovf0",  32'(bus.overflow_o), 0);
        cyc(1, 16'h5, 0, 0);
        chk("ovf_count", 32'(bus.count_o), 4);
        chk("ovf_flag",  32'(bus.overflow_o), 1);
        chk("ovf_head",  32'(bus.state_o), 32'h1);
        // Full: push with a concurrent pop is still rejected, the pop takes effect.
        cyc(1, 16'h6, 1, 0);
        chk("fullrw_count", 32'(bus.count_o), 3);
        chk("fullrw_head",  32'(bus.state_o), 32'h2);
        cyc(0, 0, 1, 0);
        chk("drain_3", 32'(bus.state_o), 32'h3);
        cyc(0, 0, 1, 0);
        chk("drain_4", 32'(bus.state_o), 32'h4);
        cyc(0, 0, 1, 0);
        chk("drain_empty", 32'(bus.valid_o), 0);
        chk("ovf_sticky",  32'(bus.overflow_o), 1);

        // Zero clears overflow; then a streaming push+pop run with pointer wrap.
        cyc(0, 0, 0, 1);
        chk("zero_ovf", 32'(bus.overflow_o), 0);
        cyc(1, 16'h20, 0, 0);
        cyc(1, 16'h21, 0, 0);
        for (int i = 0; i < 6; i++) begin
            cyc(1, 16'(16'h10 + i), 1, 0);
            chk("stream_count", 32'(bus.count_o), 2);
            chk("stream_head",  32'(bus.state_o), 32'(exp_head[i]));
        end
        cyc(0, 0, 1, 0);
        chk("stream_tail", 32'(bus.state_o), 32'h15);
        cyc(0, 0, 1, 0);
        chk("stream_empty", 32'(bus.count_o), 0);

        // Push and pop together into an empty FIFO: the push wins.
        cyc(1, 16'h7, 1, 0);
        chk("emptyrw_count", 32'(bus.count_o), 1);
        chk("emptyrw_state", 32'(bus.state_o), 32'h7);

        // Reach full + overflow, pop to 3 entries, then zero with write and read high.
        cyc(1, 16'h8, 0, 0);
        cyc(1, 16'h9, 0, 0);
        cyc(1, 16'hA, 0, 0);
        cyc(1, 16'hB, 0, 0);
        cyc(0, 0, 1, 0);
        chk("pre_zero_count", 32'(bus.count_o), 3);
        chk("pre_zero_ovf",   32'(bus.overflow_o), 1);
        cyc(1, 16'hEE, 1, 1);
        chk("zero_count", 32'(bus.count_o), 0);
        chk("zero_ovf2",  32'(bus.overflow_o), 0);
        chk("zero_state", 32'(bus.state_o), 0);
        chk("zero_ready", 32'(bus.wr_ready_o), 1);
        cyc(0, 0, 0, 0);
        chk("zero_nopush", 32'(bus.count_o), 0);

        // Asynchronous reset mid-stream, checked before any clock edge.
        cyc(1, 16'h31, 0, 0);
        cyc(1, 16'h32, 0, 0);
        chk("prerst_count", 32'(bus.count_o), 2);
        rst_n = 1'b0;
        #2;
        chk("arst_count", 32'(bus.count_o), 0);
        chk("arst_valid", 32'(bus.valid_o), 0);
        chk("arst_state", 32'(bus.state_o), 0);
        chk("arst_ready", 32'(bus.wr_ready_o), 1);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 0, 1, 0);
        chk("arst_stays_empty", 32'(bus.count_o), 0);

`ifdef INPUT_FIFO_AUTOINC_EN
        // Increment wraps the all-ones head to zero without removing it.
        cyc(1, 16'hFFFF, 0, 0);
        cyc(1, 16'h5, 0, 0);
        bus.incr_i = 1'b1;
        cyc(0, 0, 1, 0);
        bus.incr_i = 1'b0;
        chk("inc_head",  32'(bus.state_o), 0);
        chk("inc_count", 32'(bus.count_o), 2);
        chk("inc_valid", 32'(bus.valid_o), 1);
        cyc(0, 0, 1, 0);
        chk("inc_pop_head",  32'(bus.state_o), 32'h5);
        chk("inc_pop_count", 32'(bus.count_o), 1);
        // Increment plus push in the same cycle: head 5 -> 6, push 0x40 accepted.
        bus.incr_i = 1'b1;
        cyc(1, 16'h40, 1, 0);
        bus.incr_i = 1'b0;
        chk("incpush_head",  32'(bus.state_o), 32'h6);
        chk("incpush_count", 32'(bus.count_o), 2);
        cyc(0, 0, 1, 0);
        chk("incpush_next", 32'(bus.state_o), 32'h40);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
